// File: rtl/matrix_result_reader.sv
// Snapshots a packed signed result matrix and its overflow flag, then streams it as words over valid/ready.
// Optional build macro MATRIX_READER_STATUS_WORD_EN appends a status word (ovf flag + element count).
module matrix_result_reader #(
  parameter int ELEM_W = 8,
  parameter int N_ELEM = 25,
  parameter int EPW    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N_ELEM*ELEM_W-1:0] mat_in,
  input  logic                     ovf_in,
  output logic                     busy,
  output logic [EPW*ELEM_W-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [2:0]               out_idx,
  output logic                     done,
  output logic                     ovf_out
);

  localparam int WORD_W  = EPW * ELEM_W;
  localparam int MAT_W   = N_ELEM * ELEM_W;
  localparam int NW_DATA = (N_ELEM + EPW - 1) / EPW;
`ifdef MATRIX_READER_STATUS_WORD_EN
  localparam int NW      = NW_DATA + 1;
`else
  localparam int NW      = NW_DATA;
`endif
  localparam int IDX_W   = 3;
  localparam int NSLOT   = 2 ** IDX_W;
  localparam int PAD_W   = NW_DATA * WORD_W;

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t                        state, nextState;
  logic [MAT_W-1:0]              snap;
  logic [PAD_W-1:0]              padded;
  logic [NSLOT-1:0][WORD_W-1:0]  words;
  logic                          lastWord;
  logic                          xfer;

  // Slots past the last element read as zero via zero-extension of the snapshot.
  assign padded = PAD_W'(snap);

  for (genvar w = 0; w < NSLOT; w++) begin : g_word
    if (w < NW_DATA) begin : g_data
      assign words[w] = padded[w*WORD_W +: WORD_W];
    end
`ifdef MATRIX_READER_STATUS_WORD_EN
    else if (w == NW_DATA) begin : g_status
      assign words[w] = {ovf_out, (WORD_W-1-ELEM_W)'(0), ELEM_W'(N_ELEM)};
    end
`endif
    else begin : g_zero
      assign words[w] = '0;
    end
  end

  assign lastWord  = (out_idx == IDX_W'(NW - 1));
  assign xfer      = (state == SEND) && out_ready;

  assign busy      = (state == SEND);
  assign out_valid = (state == SEND);
  assign out_last  = (state == SEND) && lastWord;
  assign done      = (state == FIN);
  assign out_data  = (state == SEND) ? words[out_idx] : '0;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = SEND;
      SEND:    if (xfer && lastWord) nextState = FIN;
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      snap    <= '0;
      ovf_out <= 1'b0;
      out_idx <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && start) begin
        snap    <= mat_in;
        ovf_out <= ovf_in;
        out_idx <= '0;
      end else if (xfer && !lastWord) begin
        out_idx <= out_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_result_reader.sv
// Self-checking bench for matrix_result_reader: word model built from the element array, randomized frames.
module tb_matrix_result_reader;
`ifdef MATRIX_READER_STATUS_WORD_EN
  localparam int NW = 8;
`else
  localparam int NW = 7;
`endif

  logic         clk = 1'b0;
  logic         reset, start, ovf_in, out_ready;
  logic [199:0] mat_in;
  logic         busy, out_valid, out_last, done, ovf_out;
  logic [31:0]  out_data;
  logic [2:0]   out_idx;

  int checks = 0;
  int errors = 0;

  logic [7:0] mat [25];
  logic       ovfM;

  always #5 clk = ~clk;

  matrix_result_reader dut (
    .clk(clk), .reset(reset), .start(start), .mat_in(mat_in), .ovf_in(ovf_in),
    .busy(busy), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_idx(out_idx), .done(done), .ovf_out(ovf_out)
  );

  // Reference: word w holds elements 4w..4w+3, low element in low byte, missing elements zero.
  function automatic logic [31:0] expWord(int w);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++) begin
      int k = 4 * w + b;
      if (k < 25) r[b*8 +: 8] = mat[k];
    end
`ifdef MATRIX_READER_STATUS_WORD_EN
    if (w == 7) r = {ovfM, 23'd0, 8'd25};
`endif
    return r;
  endfunction

  task automatic loadMat();
    for (int k = 0; k < 25; k++) mat_in[k*8 +: 8] = mat[k];
    ovf_in = ovfM;
  endtask

  task automatic pulseStart();
    loadMat();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idleQuiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet cyc=%0d got valid=%b busy=%b done=%b want 0 0 0", i, out_valid, busy, done);
      end
    end
    @(posedge clk); #1;
  endtask

  // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready.
  task automatic streamFrame(input int mode, input bit disturb, input bit startInFin);
    int w = 0;
    int cyc = 0;
    bit stall = 0;
    bit finished = 0;
    logic [31:0] pd = '0;
    logic [2:0]  pi = '0;
    while (!finished && cyc < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      cyc++;
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL valid_busy w=%0d got valid=%b busy=%b want 1 1", w, out_valid, busy);
      end
      checks++;
      if (out_data !== expWord(w) || out_idx !== 3'(w) || out_last !== (w == NW - 1)) begin
        errors++;
        $display("FAIL word w=%0d got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b",
                 w, out_data, out_idx, out_last, expWord(w), 3'(w), (w == NW - 1));
      end
      if (stall) begin
        checks++;
        if (out_data !== pd || out_idx !== pi) begin
          errors++;
          $display("FAIL stall_hold got data=%h idx=%0d want data=%h idx=%0d", out_data, out_idx, pd, pi);
        end
      end
      stall = !out_ready;
      pd = out_data;
      pi = out_idx;
      if (out_ready) begin
        if (w == NW - 1) finished = 1;
        w++;
      end
      @(posedge clk); #1;
      if (disturb && w == 3 && !finished) begin
        mat_in = {25{8'h7f}};
        ovf_in = 1'b0;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL frame_timeout got words=%0d want %0d", w, NW);
    end
    out_ready = 1'b0;
    start = startInFin;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL fin got done=%b valid=%b busy=%b last=%b want 1 0 0 0", done, out_valid, busy, out_last);
    end
    checks++;
    if (ovf_out !== ovfM) begin
      errors++;
      $display("FAIL ovf_out got %b want %b", ovf_out, ovfM);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got done=%b valid=%b want 0 0", done, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; mat_in = '0; ovf_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, out_valid, out_last, done, ovf_out} !== 5'b0 || out_data !== 32'h0 || out_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%b valid=%b last=%b done=%b ovf=%b data=%h idx=%0d want all 0",
               busy, out_valid, out_last, done, ovf_out, out_data, out_idx);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idleQuiet(10);
  endtask

  task automatic test_stream();
    for (int k = 0; k < 25; k++) mat[k] = 8'(k + 1);
    ovfM = 1'b0;
    pulseStart();
    streamFrame(0, 0, 0);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 25; k++) mat[k] = 8'(k + 1);
    ovfM = 1'b0;
    pulseStart();
    streamFrame(1, 0, 1);
    idleQuiet(5);
  endtask

  task automatic test_snapshot();
    for (int k = 0; k < 25; k++) mat[k] = 8'h80;
    ovfM = 1'b1;
    pulseStart();
    streamFrame(0, 1, 0);
    idleQuiet(8);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 25; k++) mat[k] = 8'($urandom);
    ovfM = 1'($urandom);
    pulseStart();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_idx !== 3'(i) || out_data !== expWord(i)) begin
        errors++;
        $display("FAIL pre_reset_word i=%0d got idx=%0d data=%h want idx=%0d data=%h", i, out_idx, out_data, 3'(i), expWord(i));
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_idx !== 3'd0 || done !== 1'b0 || ovf_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got valid=%b busy=%b idx=%0d done=%b ovf=%b want 0 0 0 0 0",
               out_valid, busy, out_idx, done, ovf_out);
    end
    @(posedge clk); #1;
    idleQuiet(6);
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 25; k++) mat[k] = 8'($urandom);
      ovfM = 1'($urandom);
      pulseStart();
      streamFrame(2, 0, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 25; k++) mat[k] = 8'($urandom);
      ovfM = 1'($urandom);
      pulseStart();
      streamFrame(0, 0, 0);
    end
    @(posedge clk); #1;
    idleQuiet(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_snapshot();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
